// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the PS/2 pins, deserialises
// 11-bit device-to-host frames and strobes kdone/kdata for good bytes, kerr otherwise.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       kdone,
    output logic [7:0] kdata,
    output logic       kerr
);

    localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic              clk_meta, clk_sync, dat_meta, dat_sync;
    logic [FILT_W-1:0] filt_cnt;
    logic              filt_clk, filt_clk_d;
    logic              fall;

    state_t            state, state_next;
    logic [2:0]        bitcnt, bitcnt_next;
    logic [7:0]        shreg, shreg_next;
    logic              parity, parity_next;
    logic [TO_W-1:0]   to_cnt, to_cnt_next;
    logic [7:0]        kdata_next;
    logic              kdone_next, kerr_next;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
        end
    end

    // The filtered clock only follows a level held for FILTER_LEN consecutive samples.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            filt_cnt   <= '0;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            filt_clk_d <= filt_clk;
            if (clk_sync != filt_clk) begin
                if (filt_cnt == FILT_MAX) begin
                    filt_clk <= clk_sync;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall = filt_clk_d & ~filt_clk;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            parity <= 1'b0;
            to_cnt <= '0;
            kdata  <= 8'h00;
            kdone  <= 1'b0;
            kerr   <= 1'b0;
        end else begin
            state  <= state_next;
            bitcnt <= bitcnt_next;
            shreg  <= shreg_next;
            parity <= parity_next;
            to_cnt <= to_cnt_next;
            kdata  <= kdata_next;
            kdone  <= kdone_next;
            kerr   <= kerr_next;
        end
    end

    // A falling edge always wins over timeout expiry in the same cycle.
    always_comb begin
        state_next  = state;
        bitcnt_next = bitcnt;
        shreg_next  = shreg;
        parity_next = parity;
        kdata_next  = kdata;
        kdone_next  = 1'b0;
        kerr_next   = 1'b0;
        to_cnt_next = (state == IDLE) ? '0 : to_cnt + 1'b1;

        if (fall) begin
            to_cnt_next = '0;
            case (state)
                IDLE: begin
                    if (!dat_sync) begin
                        state_next  = DATA;
                        bitcnt_next = '0;
                    end
                end
                DATA: begin
                    shreg_next  = {dat_sync, shreg[7:1]};
                    bitcnt_next = bitcnt + 1'b1;
                    if (bitcnt == 3'd7)
                        state_next = PARITY;
                end
                PARITY: begin
                    parity_next = dat_sync;
                    state_next  = STOP;
                end
                STOP: begin
                    if (dat_sync && (^{shreg, parity})) begin
                        kdata_next = shreg;
                        kdone_next = 1'b1;
                    end else begin
                        kerr_next = 1'b1;
                    end
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else if (state != IDLE && to_cnt == TO_MAX) begin
            state_next  = IDLE;
            kerr_next   = 1'b1;
            shreg_next  = '0;
            bitcnt_next = '0;
            to_cnt_next = '0;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: frames are driven on the PS/2 pins, the expected
// outcome is queued from the frame rules, and a monitor pops it on each kdone/kerr strobe.
module tb_ps2_keyboard_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int HALF       = 40;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       kdone;
    logic [7:0] kdata;
    logic       kerr;

    typedef struct {
        bit         good;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_kdata = 8'h00;
    int         checks = 0;
    int         passed = 0;

    ps2_keyboard_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .kdone  (kdone),
        .kdata  (kdata),
        .kerr   (kerr)
    );

    always #20 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected)
            passed++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One PS/2 bit cell: data set while clock is high, then clock low for half a period.
    task automatic send_bit(input logic b, input bit glitch);
        ps2_dat = b;
        if (glitch) begin
            wait_cycles(15);
            ps2_clk = 1'b0;
            wait_cycles(3);
            ps2_clk = 1'b1;
            wait_cycles(HALF - 18);
        end else begin
            wait_cycles(HALF);
        end
        ps2_clk = 1'b0;
        wait_cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit bad_parity,
                                 input bit bad_stop, input bit glitch);
        logic        par;
        logic        stop;
        logic [10:0] frame;
        exp_t        e;
        par    = ~(^data) ^ bad_parity;
        stop   = ~bad_stop;
        e.good = stop && ($countones({data, par}) % 2 == 1);
        e.data = data;
        exp_q.push_back(e);
        frame = {stop, par, data, 1'b0};
        for (int i = 0; i < 11; i++)
            send_bit(frame[i], glitch);
        ps2_dat = 1'b1;
    endtask

    task automatic send_partial(input int nbits);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++)
            send_bit(1'($urandom_range(1)), 1'b0);
        ps2_dat = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clock);
        checkOutput({tag, "_kdone"}, int'(kdone), 0);
        checkOutput({tag, "_kerr"}, int'(kerr), 0);
        checkOutput({tag, "_kdata"}, int'(kdata), 0);
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            exp_kdata = 8'h00;
        end else if (kdone || kerr) begin
            checkOutput("strobe_exclusive", int'(kdone && kerr), 0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_strobe", int'({kdone, kerr}), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("strobe_kind_kdone", int'(kdone), int'(e.good));
                if (e.good) begin
                    checkOutput("kdata_new", int'(kdata), int'(e.data));
                    exp_kdata = e.data;
                end else begin
                    checkOutput("kdata_held", int'(kdata), int'(exp_kdata));
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clock);
        $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t to_err;
        wait_cycles(3);
        check_reset_state("reset");
        reset_n = 1'b1;
        wait_cycles(20);

        applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0);
        wait_cycles(60);
        applyStimulus(8'h1C, 1'b1, 1'b0, 1'b0);
        wait_cycles(60);
        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1);
        wait_cycles(60);

        send_partial(4);
        to_err.good = 1'b0;
        to_err.data = 8'h00;
        exp_q.push_back(to_err);
        wait_cycles(TIMEOUT + 50);
        applyStimulus(8'hF0, 1'b0, 1'b0, 1'b0);
        wait_cycles(60);

        send_partial(5);
        reset_n = 1'b0;
        wait_cycles(2);
        check_reset_state("midframe_reset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        wait_cycles(20);
        applyStimulus(8'h29, 1'b0, 1'b0, 1'b0);
        wait_cycles(60);

        send_bit(1'b1, 1'b0);
        applyStimulus(8'hE0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h75, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 10; n++) begin
            applyStimulus(8'($urandom_range(255)), ($urandom_range(3) == 0),
                          ($urandom_range(5) == 0), ($urandom_range(1) == 1));
            wait_cycles($urandom_range(200));
        end

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++)
            @(posedge clock);
        @(negedge clock);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
